// File: rtl/branch_sequencer_if.sv
// Fetch/retire bus between branch_sequencer, program memory and the execute stage.
// master = sequencer side, slave = memory/core side.
`timescale 1ns/1ps
interface branch_sequencer_if #(
  parameter int addr_width  = 9,
  parameter int instr_width = 16
);
  logic                   mem_req;
  logic [addr_width-1:0]  mem_addr;
  logic                   mem_ack;
  logic [instr_width-1:0] mem_data;
  logic                   instr_valid;
  logic [instr_width-1:0] instr;
  logic [addr_width-1:0]  pc;
  logic                   done;
  logic [2:0]             op;
  logic [7:0]             offset;
  logic                   carry;
  logic                   zero;
  logic                   stack_err;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, pc, stack_err,
    input  mem_ack, mem_data, done, op, offset, carry, zero
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, pc, stack_err,
    output mem_ack, mem_data, done, op, offset, carry, zero
  );
endinterface

// File: rtl/branch_sequencer.sv
// PC sequencer: fetches over req/ack, holds the word until retired, then picks the next PC.
// Optional return stack enabled by defining RETSTACK_EN (stack_err tied low otherwise).
//
// state | meaning
// IDLE  | reset only, leaves to FETCH on the first edge
// FETCH | mem_req high with mem_addr=pc, waiting for mem_ack
// ISSUE | instr_valid high, waiting for done to select the next pc
`timescale 1ns/1ps
module branch_sequencer #(
  parameter int addr_width  = 9,
  parameter int instr_width = 16,
  parameter int reset_addr  = 0,
  parameter int stack_depth = 4
) (
  input  logic clk,
  input  logic rst_n,
  branch_sequencer_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [addr_width-1:0] RST_PC = addr_width'(reset_addr);

  logic [1:0]             state;
  logic [addr_width-1:0]  pc_q;
  logic [addr_width-1:0]  seq;
  logic [addr_width-1:0]  target;
  logic [addr_width-1:0]  next_pc;
  logic                   mem_req_q;
  logic                   valid_q;
  logic [instr_width-1:0] instr_q;
  logic                   retire;

  assign retire = (state == ISSUE) && bus.done;
  assign seq    = pc_q + addr_width'(1);
  assign target = pc_q + addr_width'($signed(bus.offset));

`ifdef RETSTACK_EN
  localparam int SW = (stack_depth > 1) ? $clog2(stack_depth) : 1;

  logic [addr_width-1:0] stk_mem [stack_depth];
  logic [SW-1:0]         wp;
  logic [SW:0]           cnt;
  logic                  err_q;
  logic                  stk_empty;
  logic                  stk_full;
  logic                  do_call;
  logic                  do_ret;
  logic [addr_width-1:0] stk_top;

  assign stk_empty = (cnt == '0);
  assign stk_full  = (cnt == (SW+1)'(stack_depth));
  assign stk_top   = stk_mem[wp - SW'(1)];
  assign do_call   = retire && (bus.op == 3'b100);
  assign do_ret    = retire && (bus.op == 3'b101);
  assign bus.stack_err = err_q;

  // A full stack keeps accepting calls: the write pointer wraps over the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (do_call) begin
      wp <= wp + SW'(1);
      if (stk_full) err_q <= 1'b1;
      else          cnt   <= cnt + (SW+1)'(1);
    end else if (do_ret) begin
      if (stk_empty) begin
        err_q <= 1'b1;
      end else begin
        wp  <= wp - SW'(1);
        cnt <= cnt - (SW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_call) stk_mem[wp] <= seq;
  end
`else
  assign bus.stack_err = 1'b0;
`endif

  always_comb begin
    next_pc = seq;
    case (bus.op)
      3'b001: next_pc = target;
      3'b010: if (bus.carry) next_pc = target;
      3'b011: if (bus.zero)  next_pc = target;
`ifdef RETSTACK_EN
      3'b100: next_pc = target;
      3'b101: if (!stk_empty) next_pc = stk_top;
`endif
      default: next_pc = seq;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_q      <= RST_PC;
      mem_req_q <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state     <= FETCH;
          mem_req_q <= 1'b1;
        end
        FETCH: begin
          if (bus.mem_ack) begin
            instr_q   <= bus.mem_data;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.done) begin
            valid_q   <= 1'b0;
            pc_q      <= next_pc;
            mem_req_q <= 1'b1;
            state     <= FETCH;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: vector table, corner sequences and random
// instruction stream against a queue-based next-PC model.
`timescale 1ns/1ps
module tb_branch_sequencer;

  localparam int AW    = 9;
  localparam int IW    = 16;
  localparam int DEPTH = 4;
  localparam int NPC   = 1 << AW;

  typedef struct {
    int         start;
    logic [2:0] op;
    logic [7:0] off;
    logic       c;
    logic       z;
    int         exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  int   m_pc = 0;
  bit   m_err = 1'b0;
  int   m_stack[$];

  branch_sequencer_if #(.addr_width(AW), .instr_width(IW)) bus ();

  branch_sequencer #(
    .addr_width(AW), .instr_width(IW), .reset_addr(0), .stack_depth(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [IW-1:0] memf(input int a);
    return IW'((a * 40503) ^ 23130);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference next-PC rule, plain integer arithmetic modulo the address space.
  task automatic model_step(input logic [2:0] op, input logic [7:0] off, input logic c, input logic z);
    int seq, tgt;
    seq = (m_pc + 1) % NPC;
    tgt = (m_pc + int'($signed(off)) + NPC) % NPC;
    case (op)
      3'd1: m_pc = tgt;
      3'd2: m_pc = c ? tgt : seq;
      3'd3: m_pc = z ? tgt : seq;
`ifdef RETSTACK_EN
      3'd4: begin
        if (m_stack.size() == DEPTH) begin
          void'(m_stack.pop_front());
          m_err = 1'b1;
        end
        m_stack.push_back(seq);
        m_pc = tgt;
      end
      3'd5: begin
        if (m_stack.size() == 0) begin
          m_pc  = seq;
          m_err = 1'b1;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end
`endif
      default: m_pc = seq;
    endcase
  endtask

  // Entered at a negedge while the DUT is in FETCH; leaves at the negedge after retire.
  task automatic do_instr(input logic [2:0] op, input logic [7:0] off, input logic c, input logic z,
                          input int ack_dly, input int done_dly, input bit spur);
    check("fetch_req", bus.mem_req, 1);
    check("fetch_addr", bus.mem_addr, m_pc);
    check("fetch_valid", bus.instr_valid, 0);
    for (int i = 0; i < ack_dly; i++) begin
      if (spur) begin
        bus.done = 1'b1; bus.op = 3'b001; bus.offset = 8'h33;
      end
      @(negedge clk);
      check("wait_req", bus.mem_req, 1);
      check("wait_addr", bus.mem_addr, m_pc);
    end
    bus.done = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_data = memf(m_pc);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("issue_valid", bus.instr_valid, 1);
    check("issue_instr", bus.instr, memf(m_pc));
    check("issue_pc", bus.pc, m_pc);
    check("issue_req", bus.mem_req, 0);
    for (int i = 0; i < done_dly; i++) begin
      if (spur) begin
        bus.mem_ack = 1'b1; bus.mem_data = ~memf(m_pc);
      end
      @(negedge clk);
      check("hold_valid", bus.instr_valid, 1);
      check("hold_instr", bus.instr, memf(m_pc));
      check("hold_req", bus.mem_req, 0);
    end
    bus.mem_ack = 1'b0;
    bus.done = 1'b1; bus.op = op; bus.offset = off; bus.carry = c; bus.zero = z;
    @(negedge clk);
    bus.done = 1'b0;
    model_step(op, off, c, z);
    check("next_req", bus.mem_req, 1);
    check("next_addr", bus.mem_addr, m_pc);
    check("next_valid", bus.instr_valid, 0);
    check("stack_err", bus.stack_err, m_err);
  endtask

  task automatic go_to(input int tgt);
    int d, o;
    while (m_pc != tgt) begin
      d = (tgt - m_pc + NPC) % NPC;
      if (d <= 127)           o = d;
      else if (d >= NPC - 128) o = d - NPC;
      else                    o = 127;
      do_instr(3'b001, 8'(o), 1'b0, 1'b0, 0, 0, 1'b0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, bus.mem_req, 0);
    check({tag, "_valid"}, bus.instr_valid, 0);
    check({tag, "_instr"}, bus.instr, 0);
    check({tag, "_pc"}, bus.pc, 0);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_err"}, bus.stack_err, 0);
  endtask

  // Leaves at the negedge where the DUT has just entered FETCH.
  task automatic release_reset();
    @(negedge clk);
    check("idle_req", bus.mem_req, 0);
    rst_n = 1'b1;
    m_pc = 0; m_err = 1'b0; m_stack.delete();
    @(negedge clk);
  endtask

  vec_t vecs[$];
  int   t0, prev;

  initial begin
    bus.mem_ack = 1'b0; bus.mem_data = '0; bus.done = 1'b0;
    bus.op = 3'b000; bus.offset = 8'h00; bus.carry = 1'b0; bus.zero = 1'b0;

    vecs.push_back('{'h010, 3'd1, 8'hF0, 1'b0, 1'b0, 'h000});
    vecs.push_back('{'h1FF, 3'd0, 8'h00, 1'b0, 1'b0, 'h000});
    vecs.push_back('{'h020, 3'd2, 8'h05, 1'b1, 1'b0, 'h025});
    vecs.push_back('{'h020, 3'd2, 8'h05, 1'b0, 1'b1, 'h021});
    vecs.push_back('{'h020, 3'd3, 8'h05, 1'b0, 1'b1, 'h025});
    vecs.push_back('{'h020, 3'd3, 8'h05, 1'b1, 1'b0, 'h021});
    vecs.push_back('{'h030, 3'd6, 8'h40, 1'b1, 1'b1, 'h031});
    vecs.push_back('{'h030, 3'd7, 8'h40, 1'b1, 1'b1, 'h031});
    vecs.push_back('{'h100, 3'd1, 8'h80, 1'b0, 1'b0, 'h080});
    vecs.push_back('{'h1F0, 3'd1, 8'h7F, 1'b0, 1'b0, 'h06F});
`ifdef RETSTACK_EN
    vecs.push_back('{'h040, 3'd4, 8'h10, 1'b0, 1'b0, 'h050});
`else
    vecs.push_back('{'h040, 3'd4, 8'h10, 1'b0, 1'b0, 'h041});
    vecs.push_back('{'h060, 3'd5, 8'h10, 1'b0, 1'b0, 'h061});
`endif

    #1;
    check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", bus.mem_req, 1);
    check("first_addr", bus.mem_addr, 0);

    t0 = cyc;
    for (int i = 0; i < 4; i++) do_instr(3'b000, 8'h00, 1'b0, 1'b0, 0, 0, 1'b0);
    check("seq_cycles", 32'(cyc - t0), 8);
    check("seq_addr4", bus.mem_addr, 4);

    for (int i = 0; i < vecs.size(); i++) begin
      go_to(vecs[i].start);
      do_instr(vecs[i].op, vecs[i].off, vecs[i].c, vecs[i].z, i % 3, (i + 1) % 3, 1'b0);
      check("vec", bus.mem_addr, vecs[i].exp);
    end

    prev = m_pc;
    do_instr(3'b000, 8'h00, 1'b0, 1'b0, 3, 4, 1'b1);
    check("slow_addr", bus.mem_addr, (prev + 1) % NPC);

`ifdef RETSTACK_EN
    rst_n = 1'b0;
    release_reset();
    go_to('h040);
    do_instr(3'b100, 8'h10, 1'b0, 1'b0, 0, 0, 1'b0);
    check("call_addr", bus.mem_addr, 'h050);
    do_instr(3'b101, 8'h00, 1'b0, 1'b0, 1, 1, 1'b0);
    check("ret_addr", bus.mem_addr, 'h041);
    check("ret_err", bus.stack_err, 0);
    for (int i = 0; i < 5; i++) do_instr(3'b100, 8'h08, 1'b0, 1'b0, 0, 0, 1'b0);
    check("ovf_err", bus.stack_err, 1);
    for (int i = 0; i < 4; i++) do_instr(3'b101, 8'h00, 1'b0, 1'b0, 0, 0, 1'b0);
    prev = m_pc;
    do_instr(3'b101, 8'h00, 1'b0, 1'b0, 0, 0, 1'b0);
    check("ret5_addr", bus.mem_addr, (prev + 1) % NPC);

    rst_n = 1'b0;
    release_reset();
    do_instr(3'b101, 8'h00, 1'b0, 1'b0, 0, 0, 1'b0);
    check("empty_ret_addr", bus.mem_addr, 1);
    check("empty_ret_err", bus.stack_err, 1);
`endif

    go_to('h0AB);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_fetch");
    release_reset();
    check("restart_addr", bus.mem_addr, 0);
    do_instr(3'b001, 8'h55, 1'b0, 1'b0, 0, 0, 1'b0);
    bus.mem_ack = 1'b1; bus.mem_data = memf(m_pc);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("pre_rst_valid", bus.instr_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_issue");
    release_reset();
    check("restart2_addr", bus.mem_addr, 0);

    for (int i = 0; i < 200; i++) begin
      do_instr(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Program-counter sequencer for the small soft CPU. It owns the PC and fetches each instruction word from program memory over a req/ack handshake. It presents the word to the core and, when the core retires it, selects the next PC: sequential, unconditional relative branch, or carry/zero-conditional relative branch. Optional call/return use a small hardware return stack. It sits between program memory and the execute stage and replaces the free-standing branch adder path.

## Interface
- addr_width, 9: PC / program-memory address width; must be ≥ 8.
- instr_width, 16: instruction word width.
- reset_addr, 0: PC value loaded on reset.
- stack_depth, 4: return-stack entries, power of two; used only with RETSTACK_EN.

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_req  out  1  fetch request, held until mem_ack
- mem_addr  out  addr_width  fetch address, equals pc while mem_req=1
- mem_ack  in  1  fetch done; mem_data valid in this cycle
- mem_data  in  instr_width  instruction word
- instr_valid  out  1  instr holds a word awaiting retirement
- instr  out  instr_width  latched instruction word
- pc  out  addr_width  address of the current instruction
- done  in  1  core retires instr; sampled only while instr_valid=1
- op  in  3  next-PC select, sampled with done
- offset  in  8  signed branch offset, sampled with done
- carry  in  1  carry flag, sampled with done
- zero  in  1  zero flag, sampled with done
- stack_err  out  1  sticky return-stack overflow/underflow; 0 without RETSTACK_EN

## Operation
- States: IDLE → FETCH → ISSUE → FETCH …
  - IDLE is the reset state only. It always moves to FETCH on the next edge.
- FETCH: mem_req=1 and mem_addr=pc.
  - On an edge with mem_ack=1: instr←mem_data, mem_req←0, instr_valid←1, go to ISSUE.
- ISSUE: the core may hold instr_valid high for any number of cycles.
  - On an edge with done=1: instr_valid←0, pc←next, mem_req←1, go to FETCH.
- target = (pc + sign_extend(offset)) mod 2^addr_width.
- seq = (pc + 1) mod 2^addr_width. Both wrap silently.
- Next-PC select by op:
  - 000: seq.
  - 001: target.
  - 010: carry ? target : seq.
  - 011: zero ? target : seq.
  - 100: call (RETSTACK_EN only).
  - 101: return (RETSTACK_EN only).
  - 110, 111: seq.
- mem_ack outside FETCH and done outside ISSUE are ignored.

## Timing
- Reset values:
  - state=IDLE, pc=reset_addr, mem_req=0, instr_valid=0, instr=0.
  - Stack pointer=0, stack_err=0.
- mem_req rises on the first edge after rst_n deasserts.
- Fetch latency: instr_valid=1 on the edge that samples mem_ack=1.
  - Zero-wait memory: mem_req high for 1 cycle, then instr_valid high the next cycle.
- Retire-to-fetch: mem_req=1 with the new mem_addr on the edge that samples done.
- Minimum loop is 2 cycles per instruction (ack and done each in the first possible cycle).
- All outputs are registered. No combinational path from any input to any output.
- rst_n assertion in any state applies reset values immediately.
  - A pending memory transaction is abandoned.
  - Memory must drop any in-flight ack on reset.

## Configuration
- RETSTACK_EN defined:
  - Adds a stack_depth-entry return stack.
  - op=100: push seq, pc←target. If the stack is full, the oldest entry is overwritten (circular pointer) and stack_err←1.
  - op=101: pop, pc←popped value. If the stack is empty, pc←seq and stack_err←1.
  - stack_err is cleared only by reset.
- RETSTACK_EN undefined:
  - No stack storage.
  - op=100 and op=101 behave as 000.
  - stack_err is tied to 0.

## Test plan
- Reset then zero-wait memory, op=000 each retire → mem_addr sequence 0,1,2,3; one instruction per 2 cycles.
- pc=0x010, op=001, offset=0xF0 → next mem_addr=0x000. pc=0x1FF, op=000 → next mem_addr=0x000 (wrap).
- pc=0x020, offset=0x05:
  - op=010 with carry=1 → 0x025; with carry=0 → 0x021.
  - op=011 with zero=1 → 0x025; with zero=0 → 0x021.
- mem_ack delayed 3 cycles and done held off 4 cycles:
  - mem_req/mem_addr stable throughout; instr_valid stays 1 until done.
  - Spurious ack during ISSUE is ignored.
- RETSTACK_EN, stack_depth=4:
  - Call from 0x040 offset 0x10 → 0x050; return → 0x041.
  - 5 nested calls then 5 returns → 5th return goes to seq and stack_err=1.
  - Return on an empty stack → pc+1 and stack_err=1.
- Assert rst_n mid-FETCH and mid-ISSUE → all outputs at reset values immediately; mem_addr=reset_addr on restart.
